// File: rtl/immu_line_fill_if.sv
// Word-read bus between the line-fill engine and the backing instruction memory.
// The master drives requests; the slave grants them and returns data in issue order.
interface immu_line_fill_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/immu_line_fill.sv
// Instruction-cache line fill: issues eight word reads with a bounded number outstanding,
// assembles the returned words into a 256-bit line and pulses immu_done when complete.
//
// state   | meaning
// IDLE    | waiting for immu_read; base latched on request
// FILL    | issuing word reads and collecting in-order responses
// DONE    | line complete, immu_done high for this one cycle
module immu_line_fill #(
  parameter int MAX_OUTS   = 2,
  parameter int LINE_WORDS = 8
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       immu_read,
  input  logic [31:0]                immu_addr,
  output logic                       immu_done,
  output logic [LINE_WORDS*32-1:0]   immu_read_data,
  immu_line_fill_if.master           mem
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LINE_CNT = 4'(LINE_WORDS);
  localparam logic [3:0] OUTS_MAX = 4'(MAX_OUTS);

  logic [1:0]  state;
  logic [31:0] base;
  logic [3:0]  issue_cnt;
  logic [3:0]  recv_cnt;
  logic [3:0]  outstanding;
  logic        issue;
  logic        recv;
  logic        unused_addr_bits;

  // Offset within the line is discarded; the whole line is always fetched from word 0.
  assign unused_addr_bits = ^immu_addr[4:0];

  assign outstanding  = issue_cnt - recv_cnt;
  assign mem.mem_req  = (state == ST_FILL) && (issue_cnt < LINE_CNT) && (outstanding < OUTS_MAX);
  assign mem.mem_addr = base + {26'd0, issue_cnt, 2'b00};
  assign issue        = mem.mem_req & mem.mem_gnt;
  assign recv         = (state == ST_FILL) & mem.mem_rvalid & (recv_cnt < LINE_CNT);
  assign immu_done    = (state == ST_DONE);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      base           <= 32'd0;
      issue_cnt      <= 4'd0;
      recv_cnt       <= 4'd0;
      immu_read_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (immu_read) begin
            base      <= {immu_addr[31:5], 5'b0};
            issue_cnt <= 4'd0;
            recv_cnt  <= 4'd0;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (issue) issue_cnt <= issue_cnt + 4'd1;
          // Slots are overwritten in place, so the previous line stays visible until word 0 lands.
          if (recv) begin
            immu_read_data[{recv_cnt[2:0], 5'b0} +: 32] <= mem.mem_rdata;
            recv_cnt <= recv_cnt + 4'd1;
            if (recv_cnt == LINE_CNT - 4'd1) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          issue_cnt <= 4'd0;
          recv_cnt  <= 4'd0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_immu_line_fill.sv
// Bench for immu_line_fill: table of fill scenarios against a latency/grant-randomised
// memory model, with queued expected addresses and lines, plus reset and idle corner cases.
module tb_immu_line_fill;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         immu_read;
  logic [31:0]  immu_addr;
  logic         immu_done;
  logic [255:0] immu_read_data;

  immu_line_fill_if bus ();

  immu_line_fill #(.MAX_OUTS(2), .LINE_WORDS(8)) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .immu_read      (immu_read),
    .immu_addr      (immu_addr),
    .immu_done      (immu_done),
    .immu_read_data (immu_read_data),
    .mem            (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    int          gnt_pct;
    int          lat;
    logic [31:0] salt;
    int          drop_after;
    logic [31:0] first_addr;
    logic [31:0] last_addr;
  } vec_t;

  resp_t        resp_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [255:0] exp_line_q[$];

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           gnt_pct = 100;
  int           lat = 1;
  logic [31:0]  salt = 32'h0;
  int           n_grant, n_recv, n_done;
  logic         prev_stall;
  logic [31:0]  prev_addr, first_addr, last_addr;
  logic [255:0] last_line;
  vec_t         vecs[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not observed as required", name);
  endtask

  // One clock: drive memory-side inputs, sample DUT outputs, take the edge, update the model.
  task automatic cycle();
    logic        req, gnt, rv;
    logic [31:0] addr;
    resp_t       r;
    gnt = ($urandom_range(0, 99) < gnt_pct);
    rv  = (resp_q.size() > 0) && (resp_q[0].due <= cyc);
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rv ? resp_q[0].data : 32'h0;
    #1;
    req  = bus.mem_req;
    addr = bus.mem_addr;
    if (prev_stall) begin
      chk("stall_req_held", req, 1);
      chk("stall_addr_held", addr, prev_addr);
    end
    if (immu_done) begin
      n_done++;
      if (exp_line_q.size() > 0) chk("line_data", immu_read_data, exp_line_q.pop_front());
      else fail("unexpected_done");
    end
    @(posedge sys_clk);
    cyc++;
    if (req && gnt) begin
      if (exp_addr_q.size() > 0) chk("mem_addr_order", addr, exp_addr_q.pop_front());
      else fail("extra_grant");
      if (n_grant == 0) first_addr = addr;
      last_addr = addr;
      n_grant++;
      r.data = salt + {29'd0, addr[4:2]};
      r.due  = cyc + lat - 1;
      resp_q.push_back(r);
    end
    if (rv) begin
      void'(resp_q.pop_front());
      n_recv++;
    end
    if (req && gnt) chk("outstanding_le_max", ((n_grant - n_recv) <= 2), 1);
    prev_stall = req && !gnt;
    prev_addr  = addr;
    #1;
  endtask

  task automatic run_fill(input vec_t v, input int abort_rv);
    logic [31:0]  base;
    logic [255:0] line;
    base = v.addr & 32'hFFFF_FFE0;
    salt = v.salt;
    gnt_pct = v.gnt_pct;
    lat = v.lat;
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(base + 32'(4 * k));
      line[k*32 +: 32] = v.salt + 32'(k);
    end
    exp_line_q.push_back(line);
    n_grant = 0;
    n_recv = 0;
    n_done = 0;
    prev_stall = 1'b0;
    immu_addr = v.addr;
    immu_read = 1'b1;
    for (int t = 0; t < 400 && n_done == 0; t++) begin
      if (n_grant >= v.drop_after) immu_read = 1'b0;
      cycle();
      if (abort_rv > 0 && n_recv >= abort_rv) return;
    end
    if (n_done == 0) fail("done_timeout");
    immu_read = 1'b0;
    for (int t = 0; t < 3; t++) begin
      cycle();
      chk("idle_mem_req", bus.mem_req, 0);
    end
    chk("done_pulse_count", n_done, 1);
    chk("grant_count", n_grant, 8);
    chk("first_mem_addr", first_addr, v.first_addr);
    chk("last_mem_addr", last_addr, v.last_addr);
    last_line = line;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 100, 1, 32'hA000_0000, 99, 32'h0000_1000, 32'h0000_101C};
    vecs[1] = '{32'hFFFF_E014, 100, 1, 32'h1234_5600, 99, 32'hFFFF_E000, 32'hFFFF_E01C};
    vecs[2] = '{32'h0000_3044,  50, 3, 32'h5A5A_0000, 99, 32'h0000_3040, 32'h0000_305C};
    vecs[3] = '{32'hFFFF_FFE8,  70, 2, 32'hC0DE_0000, 99, 32'hFFFF_FFE0, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0000_4000, 100, 2, 32'h7700_0000,  2, 32'h0000_4000, 32'h0000_401C};
    vecs[5] = '{32'h0000_ABCD,  30, 4, 32'h3300_0000,  5, 32'h0000_ABC0, 32'h0000_ABDC};

    rst = 1'b1;
    immu_read = 1'b1;
    immu_addr = 32'h0000_1000;
    bus.mem_gnt = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      chk("rst_immu_done", immu_done, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_read_data", immu_read_data, 0);
    end
    rst = 1'b0;
    immu_read = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("idle_after_rst_req", bus.mem_req, 0);

    for (int i = 0; i < 6; i++) run_fill(vecs[i], 0);

    // Stray responses while idle must not touch the line or the FSM.
    bus.mem_gnt = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(posedge sys_clk);
      #1;
      chk("idle_rvalid_req", bus.mem_req, 0);
      chk("idle_rvalid_done", immu_done, 0);
      chk("idle_rvalid_data", immu_read_data, last_line);
    end
    bus.mem_rvalid = 1'b0;

    // Reset after three responses abandons the fill; a fresh fill must then complete cleanly.
    run_fill('{32'h0000_5000, 100, 3, 32'h9900_0000, 99, 32'h0000_5000, 32'h0000_501C}, 3);
    rst = 1'b1;
    immu_read = 1'b1;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    resp_q.delete();
    exp_addr_q.delete();
    exp_line_q.delete();
    prev_stall = 1'b0;
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      chk("midrst_read_data", immu_read_data, 0);
      chk("midrst_mem_req", bus.mem_req, 0);
      chk("midrst_mem_addr", bus.mem_addr, 0);
      chk("midrst_done", immu_done, 0);
    end
    rst = 1'b0;
    immu_read = 1'b0;
    @(posedge sys_clk);
    #1;
    run_fill('{32'h0000_2000, 60, 2, 32'h2000_0000, 99, 32'h0000_2000, 32'h0000_201C}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
